// File: rtl/dp_ram_dbg.sv
// Dual-port (1R/1W) RAM with lane-masked writes, optional write-to-read forwarding,
// a post-reset initialisation sweep and a single-transaction debug port that preempts functional traffic.
module dp_ram_dbg #(
    parameter int                         ADDR_WIDTH    = 6,
    parameter int                         DATA_WIDTH    = 64,
    parameter int                         MASK_GRAN     = 8,
    parameter int                         INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]      INIT_VALUE    = '0,
    parameter int                         WR_FWD        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              ready,
    output logic                              init_busy,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0]   wr_mask,
    input  logic                              dbg_req,
    input  logic                              dbg_we,
    input  logic [ADDR_WIDTH-1:0]             dbg_addr,
    input  logic [DATA_WIDTH-1:0]             dbg_wdata,
    output logic                              dbg_ack,
    output logic [DATA_WIDTH-1:0]             dbg_rdata,
    output logic [1:0]                        state_dbg
);

    localparam int MW    = DATA_WIDTH / MASK_GRAN;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] INIT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    // Handshake: functional rd_en/wr_en take effect only in a cycle where ready=1;
    // otherwise they are dropped. dbg_req is a level held by the requester; each
    // transaction completes with exactly one dbg_ack pulse, even if dbg_req falls early.

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DBG_ACC = 2'd2,
        ST_DBG_ACK = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH:0]     init_cnt;
    logic                    cap_we;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   wr_bits;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_wbits;
    logic [DATA_WIDTH-1:0]   rd_old;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    fwd_hit;

    assign ready     = (state == ST_IDLE) && !dbg_req && !rst;
    assign init_busy = (state == ST_INIT);
    assign state_dbg = state;

    always_comb begin
        wr_bits = '0;
        for (int i = 0; i < MW; i++) begin
            wr_bits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wr_mask[i]}};
        end
    end

    // Single physical write port shared by the sweep, debug and functional writers.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbits = wr_bits;
        case (state)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt[ADDR_WIDTH-1:0];
                mem_wdata = INIT_VALUE;
                mem_wbits = '1;
            end
            ST_DBG_ACC: begin
                mem_we    = cap_we;
                mem_waddr = cap_addr;
                mem_wdata = cap_wdata;
                mem_wbits = '1;
            end
            ST_IDLE: mem_we = ready && wr_en;
            default: mem_we = 1'b0;
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wbits) | (mem_wdata & mem_wbits);
        end
    end

    assign rd_old  = mem[rd_addr];
    assign fwd_hit = (WR_FWD != 0) && wr_en && (wr_addr == rd_addr);
    assign rd_word = fwd_hit ? ((rd_old & ~wr_bits) | (wr_data & wr_bits)) : rd_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            init_cnt  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            rd_valid <= 1'b0;
            dbg_ack  <= 1'b0;
            if (ready && rd_en) begin
                rd_data  <= rd_word;
                rd_valid <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (dbg_req) begin
                        cap_we    <= dbg_we;
                        cap_addr  <= dbg_addr;
                        cap_wdata <= dbg_wdata;
                        state     <= ST_DBG_ACC;
                    end
                end
                ST_DBG_ACC: begin
                    // A debug write reports the word it wrote.
                    dbg_rdata <= cap_we ? cap_wdata : mem[cap_addr];
                    dbg_ack   <= 1'b1;
                    state     <= ST_DBG_ACK;
                end
                ST_DBG_ACK: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dp_ram_dbg.md
# dp_ram_dbg

Parametrised dual-port RAM (one read port, one write port) with mask-granular writes, optional write-to-read forwarding, on-reset initialisation to a programmable value and a parallel request/acknowledge debug access port. Next generation of the cache SRAM wrapper: replaces nibble-serial BIST access with a single-transaction debug port that takes priority over functional traffic. Sits between the dcache data/tag arrays and the debug fabric; storage is a behavioural array.

## Interface
- ADDR_WIDTH, 6: address bits; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 64: word width.
- MASK_GRAN, 8: bits per write-mask lane; DATA_WIDTH must be a multiple; MW = DATA_WIDTH/MASK_GRAN.
- INIT_ON_RESET, 1: 1 = sweep all words to INIT_VALUE after reset.
- INIT_VALUE, 0: DATA_WIDTH-wide init pattern.
- WR_FWD, 1: 1 = same-address same-cycle read returns new data; 0 = returns old data.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  functional ports accepted this cycle.
- init_busy  out  1  initialisation sweep in progress.
- rd_en  in  1  functional read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, held until next accepted read.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- wr_en  in  1  functional write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  MW  lane i=1 writes bits [i*MASK_GRAN +: MASK_GRAN].
- dbg_req  in  1  debug request, level; held until dbg_ack.
- dbg_we  in  1  1 write, 0 read.
- dbg_addr  in  ADDR_WIDTH  debug address.
- dbg_wdata  in  DATA_WIDTH  debug write data (full word).
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_WIDTH  read result (write: word written), valid with dbg_ack, held after.

## Operation
- FSM states INIT, IDLE, DBG_ACC, DBG_ACK.
- Reset: state = INIT if INIT_ON_RESET=1 else IDLE; init counter 0; rd_data, dbg_rdata = 0; rd_valid, dbg_ack, ready = 0; init_busy = INIT_ON_RESET. Memory array not cleared by rst itself.
- INIT: each cycle writes INIT_VALUE (all lanes) to counter address, counter +1; after address DEPTH-1 -> IDLE. Counter is ADDR_WIDTH+1 bits; terminal detect at DEPTH-1, no wrap. init_busy=1, ready=0 throughout.
- IDLE: ready = !dbg_req. ready=1: rd_en/wr_en act on array. ready=0: functional requests dropped, no side effects; requester re-issues. dbg_req=1 in IDLE: capture dbg_we/addr/wdata -> DBG_ACC.
- DBG_ACC: captured op on array; write uses full mask. Functional ports blocked. -> DBG_ACK.
- DBG_ACK: dbg_ack=1, dbg_rdata = read word or written word. Functional ports blocked. -> IDLE. dbg_req still high in the following IDLE cycle = new transaction.
- Masked write: lanes with mask 0 keep old contents; wr_mask=0 is a no-op.
- Same-address read and write same cycle: WR_FWD=1 -> rd_data = per-lane merge (masked lanes new, others old); WR_FWD=0 -> full old word. Write always commits.
- Different addresses same cycle: independent.

## Timing
- Functional read: rd_en accepted in cycle N -> rd_data/rd_valid in N+1. rd_valid=0 in cycles with no accepted read; rd_data holds.
- Functional write: visible to a read accepted in N+1 (and in N if WR_FWD=1).
- Debug: dbg_req sampled in IDLE cycle N -> op in N+1 -> dbg_ack in N+2. ready=0 in N, N+1, N+2.
- Init: rst low first in cycle C -> writes C..C+DEPTH-1; init_busy falls, ready may rise, in C+DEPTH.
- dbg_req during INIT: held, served in first IDLE cycle.
- rst mid-operation: aborts any sweep or debug transaction next edge, no dbg_ack; sweep restarts from 0.
- dbg_req dropped before ack: transaction still completes; ack still pulses.

## Test plan
- Init: ADDR_WIDTH=4, INIT_VALUE=64'hA5A5_A5A5_A5A5_A5A5, release rst -> init_busy high 16 cycles; reads of 0 and 15 return A5A5.. with rd_valid one cycle later.
- Masked write: write 64'h1122334455667788 to addr 3 mask 8'hFF, then 64'hFFFF..FF mask 8'h0F -> read addr 3 = 64'h11223344FFFFFFFF.
- Collision: addr 5 = 0; same cycle wr_addr=rd_addr=5, data 64'hDEAD, mask FF -> WR_FWD=1 rd_data 64'hDEAD; WR_FWD=0 rd_data 0; next read 64'hDEAD both.
- Debug priority: dbg_req write 64'hBEEF addr 7 with rd_en/wr_en held high to addr 9 -> ready=0 three cycles, dbg_ack in cycle N+2, dbg_rdata 64'hBEEF, addr 9 untouched; debug read of 7 returns 64'hBEEF.
- dbg_req asserted during INIT -> no ack until init_busy falls; ack exactly 2 cycles after first IDLE cycle.
- rst asserted in DBG_ACC -> no dbg_ack, all outputs reset values next cycle, sweep restarts at address 0.
